// File: rtl/if_prefetch_buf.sv
// Instruction prefetch buffer between IF and a 1-cycle synchronous I-memory.
// Optional redirect statistics counter: define PREFETCH_STATS_EN.
module if_prefetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RSTn,
  output logic        I_MEM_CSN,
  output logic [31:0] I_MEM_ADDR,
  input  logic [31:0] I_MEM_DI,
  input  logic        IF_REQ,
  output logic        IF_VALID,
  output logic [31:0] IF_INST,
  output logic [31:0] IF_PC,
  input  logic        REDIR,
  input  logic [31:0] REDIR_PC,
  output logic [15:0] FLUSH_CNT
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            infl_q, infl_d;
  logic [31:0]     infl_pc_q, infl_pc_d;
  logic [31:0]     fpc_q, fpc_d;

  logic            pop;
  logic            push;
  logic            issue;
  logic [31:0]     redir_addr;
  logic [AW+1:0]   occ;

  always_comb begin
    redir_addr = REDIR_PC & 32'hFFFF_FFFC;
    pop        = IF_REQ & (count_q != '0) & ~REDIR;
    push       = infl_q & ~REDIR;
    // Occupancy includes the in-flight fetch so its response always has a slot.
    occ        = {1'b0, count_q} + (AW+2)'(infl_q) - (AW+2)'(pop);
    // Reset gates the chip select combinationally so it drops asynchronously.
    issue      = RSTn & (REDIR | (occ < (AW+2)'(DEPTH)));
    I_MEM_CSN  = ~issue;
    I_MEM_ADDR = (REDIR & RSTn) ? redir_addr : fpc_q;

    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    infl_d     = infl_q;
    infl_pc_d  = infl_pc_q;
    fpc_d      = fpc_q;

    if (REDIR) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      infl_d    = 1'b1;
      infl_pc_d = redir_addr;
      fpc_d     = redir_addr + 32'd4;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: infl_pc_q, inst: I_MEM_DI};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      infl_d  = issue;
      if (issue) begin
        infl_pc_d = fpc_q;
        fpc_d     = fpc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      fpc_q     <= RESET_PC;
    end else begin
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      fpc_q     <= fpc_d;
    end
  end

  always_comb begin
    IF_VALID = (count_q != '0);
    IF_INST  = IF_VALID ? mem_q[rd_ptr_q].inst : '0;
    IF_PC    = IF_VALID ? mem_q[rd_ptr_q].pc   : '0;
  end

`ifdef PREFETCH_STATS_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (REDIR && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      flush_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign FLUSH_CNT = flush_cnt_q;
`else
  assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Self-checking bench for if_prefetch_buf: cycle-level queue model of the buffer
// plus a second instance exercising fetch-address wraparound from a high RESET_PC.
module tb_if_prefetch_buf;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        csn;
  logic [31:0] addr;
  logic [31:0] di;
  logic        req;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        redir;
  logic [31:0] redir_pc;
  logic [15:0] flush_cnt;

  logic        w_rstn;
  logic        w_csn;
  logic [31:0] w_addr;
  logic [31:0] w_di;
  logic        w_req = 1'b1;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic        w_redir = 1'b0;
  logic [31:0] w_redir_pc = '0;
  logic [15:0] w_flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Queue model: PCs held in the buffer, plus the one fetch in flight.
  logic [31:0] m_q[$];
  logic [31:0] m_fpc;
  bit          m_infl;
  logic [31:0] m_infl_pc;

  always #5 clk = ~clk;

  if_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .RSTn(rstn), .I_MEM_CSN(csn), .I_MEM_ADDR(addr), .I_MEM_DI(di),
    .IF_REQ(req), .IF_VALID(valid), .IF_INST(inst), .IF_PC(pc),
    .REDIR(redir), .REDIR_PC(redir_pc), .FLUSH_CNT(flush_cnt)
  );

  if_prefetch_buf #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .CLK(clk), .RSTn(w_rstn), .I_MEM_CSN(w_csn), .I_MEM_ADDR(w_addr), .I_MEM_DI(w_di),
    .IF_REQ(w_req), .IF_VALID(w_valid), .IF_INST(w_inst), .IF_PC(w_pc),
    .REDIR(w_redir), .REDIR_PC(w_redir_pc), .FLUSH_CNT(w_flush_cnt)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a >> 2;
  endfunction

  always @(posedge clk) begin
    if (!csn) di <= memfn(addr);
    if (!w_csn) w_di <= memfn(w_addr);
  end

  task automatic model_reset();
    m_q.delete();
    m_fpc     = 32'h0000_0000;
    m_infl    = 1'b0;
    m_infl_pc = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0; req = 1'b0; redir = 1'b0; redir_pc = '0;
    @(posedge clk); #2;
    rstn = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit r, input bit rd, input logic [31:0] rpc);
    bit          exp_valid, mpop, missue;
    logic [31:0] tgt, exp_addr, hpc;
    @(negedge clk);
    req = r; redir = rd; redir_pc = rpc;
    #1;
    tgt       = rpc & 32'hFFFF_FFFC;
    exp_valid = (m_q.size() != 0);
    hpc       = exp_valid ? m_q[0] : 32'h0;
    mpop      = r && exp_valid && !rd;
    missue    = rd || ((m_q.size() + int'(m_infl) - int'(mpop)) < int'(DEPTH));
    exp_addr  = rd ? tgt : m_fpc;

    n_checks++;
    if (csn !== !missue) $display("FAIL csn t=%0t got %b want %b", $time, csn, !missue);
    else n_pass++;
    n_checks++;
    if (addr !== exp_addr) $display("FAIL addr t=%0t got %h want %h", $time, addr, exp_addr);
    else n_pass++;
    n_checks++;
    if (valid !== exp_valid) $display("FAIL valid t=%0t got %b want %b", $time, valid, exp_valid);
    else n_pass++;
    n_checks++;
    if (pc !== hpc) $display("FAIL if_pc t=%0t got %h want %h", $time, pc, hpc);
    else n_pass++;
    n_checks++;
    if (inst !== (exp_valid ? memfn(hpc) : 32'h0))
      $display("FAIL if_inst t=%0t got %h want %h", $time, inst, exp_valid ? memfn(hpc) : 32'h0);
    else n_pass++;

    if (rd) begin
      m_q.delete();
      m_infl    = 1'b1;
      m_infl_pc = tgt;
      m_fpc     = tgt + 32'd4;
    end else begin
      if (mpop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      if (missue) begin
        m_infl    = 1'b1;
        m_infl_pc = m_fpc;
        m_fpc     = m_fpc + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0; req = 1'b1; redir = 1'b0; redir_pc = '0;
    #1;
    n_checks++;
    if (csn !== 1'b1) $display("FAIL reset_csn got %b want 1", csn); else n_pass++;
    n_checks++;
    if (addr !== 32'h0) $display("FAIL reset_addr got %h want 0", addr); else n_pass++;
    n_checks++;
    if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
    n_checks++;
    if ({inst, pc} !== 64'h0) $display("FAIL reset_inst_pc got %h/%h want 0/0", inst, pc); else n_pass++;
    n_checks++;
    if (flush_cnt !== 16'h0) $display("FAIL reset_flush got %h want 0", flush_cnt); else n_pass++;
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (m_q.size() != 4 || valid !== 1'b1 || pc !== 32'h0)
      $display("FAIL fill_full got valid=%b pc=%h want valid=1 pc=0", valid, pc);
    else n_pass++;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_redirect();
    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_redir_pop();
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0800);
    step(1'b1, 1'b1, 32'h0000_0900);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom());
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (valid !== 1'b0 || csn !== 1'b1)
      $display("FAIL async_reset got valid=%b csn=%b want valid=0 csn=1", valid, csn);
    else n_pass++;
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_flush_cnt();
    int exp;
    apply_reset();
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0300);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0400);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
`ifdef PREFETCH_STATS_EN
    exp = 3;
`else
    exp = 0;
`endif
    n_checks++;
    if (flush_cnt !== 16'(exp)) $display("FAIL flush_cnt got %0d want %0d", flush_cnt, exp);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    @(negedge clk);
    w_rstn = 1'b0;
    @(posedge clk); #2;
    w_rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (i < 3) begin
        n_checks++;
        if (w_csn !== 1'b0 || w_addr !== exp_a[i])
          $display("FAIL wrap_addr%0d got csn=%b addr=%h want 0/%h", i, w_csn, w_addr, exp_a[i]);
        else n_pass++;
      end
      if (i >= 2) begin
        n_checks++;
        if (w_valid !== 1'b1 || w_pc !== exp_a[i-2] || w_inst !== memfn(exp_a[i-2]))
          $display("FAIL wrap_head%0d got v=%b pc=%h inst=%h want 1/%h/%h",
                   i, w_valid, w_pc, w_inst, exp_a[i-2], memfn(exp_a[i-2]));
        else n_pass++;
      end
    end
  endtask

  initial begin
    rstn = 1'b0; w_rstn = 1'b0;
    req = 1'b0; redir = 1'b0; redir_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_stream();
    test_fill();
    test_redirect();
    test_redir_pop();
    test_async_reset();
    test_flush_cnt();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_prefetch_buf.md
Name: if_prefetch_buf

Overview:
Instruction prefetch buffer between the core's fetch stage and the I-memory SP_SRAM (1-cycle synchronous read).
- Issues sequential word fetches ahead of the core and holds up to DEPTH instructions with their PCs.
- Presents instructions to IF/ID through a valid/request handshake.
- Flushes everything and restarts fetch on a branch/jump redirect from the core.

Parameters:
DEPTH, 4, buffer entries; power of two, minimum 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RSTn  input  1  asynchronous, active-low reset.
I_MEM_CSN  output  1  I-memory chip select, active low; low means a fetch is issued this cycle.
I_MEM_ADDR  output  32  fetch byte address; the SRAM uses bits [11:2].
I_MEM_DI  input  32  I-memory read data; valid one cycle after the issue cycle.
IF_REQ  input  1  core consumes the head entry this cycle.
IF_VALID  output  1  head entry is valid.
IF_INST  output  32  head instruction.
IF_PC  output  32  head instruction's PC.
REDIR  input  1  redirect/flush request from the core (taken branch, jump).
REDIR_PC  input  32  redirect target; bits [1:0] are ignored and treated as 0.
FLUSH_CNT  output  16  redirect counter; see Optional Feature.

Behaviour:
- State:
  - fpc: next fetch address.
  - FIFO: DEPTH x {pc, inst}, with rd_ptr and wr_ptr of log2(DEPTH) bits that wrap naturally.
  - count: log2(DEPTH)+1 bits.
  - infl: 1 bit; a fetch was issued last cycle.
  - infl_pc: PC of that in-flight fetch.
- Reset (async, RSTn low):
  - fpc=RESET_PC; pointers, count and infl cleared.
  - I_MEM_CSN=1, I_MEM_ADDR=RESET_PC, IF_VALID=0, IF_INST=0, IF_PC=0, FLUSH_CNT=0.
- pop = IF_REQ & IF_VALID & ~REDIR. IF_REQ while the buffer is empty is ignored.
- Issue condition, when REDIR=0: (count + infl - pop) < DEPTH. Counting infl is what keeps the SRAM response from ever overflowing the FIFO.
- Issue cycle (combinational outputs):
  - I_MEM_CSN=0, I_MEM_ADDR=fpc.
  - Registered update: infl<=1, infl_pc<=fpc, fpc<=fpc+4.
  - fpc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- No-issue cycle: I_MEM_CSN=1, I_MEM_ADDR=fpc; infl<=0.
- Response cycle (infl=1, REDIR=0): {infl_pc, I_MEM_DI} is written at wr_ptr and wr_ptr increments.
- count update: count <= count + push - pop. A simultaneous push and pop leaves count unchanged.
- IF_VALID = (count != 0). IF_INST and IF_PC are driven from the entry at rd_ptr.
- Latency:
  - Fetch issued at cycle t is written at the end of t+1 and visible as IF_VALID at t+2.
  - Steady state with IF_REQ held high delivers one instruction per cycle.
- REDIR=1, which has priority over everything:
  - FIFO cleared (rd_ptr=wr_ptr=0, count=0); pop suppressed.
  - The in-flight response arriving this cycle is discarded.
  - Same-cycle zero-bubble fetch: I_MEM_CSN=0, I_MEM_ADDR={REDIR_PC[31:2],2'b00}; fpc<=that address+4; infl<=1; infl_pc<=that address.
  - IF_VALID is 0 in the cycle after REDIR; the target instruction is valid 2 cycles after REDIR.
  - Back-to-back REDIRs: only the last target survives.
- Full (count=DEPTH): no issue. A pop in the same cycle permits an issue per the formula above.
- Reset mid-operation: all state is cleared immediately. The in-flight response is never written, because infl is cleared.

Optional Feature:
Macro PREFETCH_STATS_EN.
- Defined: FLUSH_CNT increments on every cycle with REDIR=1, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: the counter logic is not compiled and FLUSH_CNT is tied to 16'h0000. The port is kept so the interface is unchanged.

Test Plan:
1. Reset, IF_REQ=1 constant, memory holds word[i]=i → I_MEM_CSN low from cycle 0 with ADDR 0,4,8…; IF_VALID first high at cycle 2 with PC=0, INST=0, then PC=4, INST=1, … one per cycle with no gaps.
2. IF_REQ=0 from reset, DEPTH=4 → exactly 4 issues (ADDR 0,4,8,12), then I_MEM_CSN stays high; count=4; head PC=0. Raising IF_REQ gives PCs 0,4,8,12,16 in consecutive cycles.
3. Steady stream, REDIR=1 with REDIR_PC=32'h0000_0103 while an entry is in flight → same-cycle I_MEM_ADDR=0x100; next cycle IF_VALID=0; the following cycle IF_PC=0x100. No stale PC is ever presented.
4. REDIR and IF_REQ asserted together with count=3 → no pop, FIFO empty afterward; the popped entry never appears on IF_PC.
5. Reset with fpc=RESET_PC=32'hFFFF_FFF8 and a stream running → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. Asserting RSTn=0 mid-stream forces IF_VALID=0 and I_MEM_CSN=1 asynchronously.
6. PREFETCH_STATS_EN defined, 3 REDIR pulses → FLUSH_CNT=3. Undefined → FLUSH_CNT=0.
